// File: rtl/rd_issue_stage_if.sv
// rd_issue_stage_if: upstream bundle, forwarding, control and downstream signals of rd_issue_stage
interface rd_issue_stage_if #(
  parameter int LANES    = 2,
  parameter int DATA_W   = 32,
  parameter int FWD_SRCS = 3,
  parameter int CNT_W    = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic [LANES-1:0]             in_lane_valid;
  logic [6*LANES-1:0]           in_opcode;
  logic [5*LANES-1:0]           in_rd;
  logic [LANES-1:0]             in_reg_write;
  logic [LANES-1:0]             in_branch;
  logic [5*LANES-1:0]           in_shamt;
  logic [6*LANES-1:0]           in_funct;
  logic [16*LANES-1:0]          in_imm;
  logic [26*LANES-1:0]          in_target;
  logic [DATA_W-1:0]            in_pc;
  logic [DATA_W*LANES-1:0]      in_rs_val;
  logic [DATA_W*LANES-1:0]      in_rt_val;
  logic [FWD_SRCS*LANES-1:0]    fwd_hit_rs;
  logic [FWD_SRCS*LANES-1:0]    fwd_hit_rt;
  logic [DATA_W*FWD_SRCS-1:0]   fwd_val;
  logic                         hazard_stall;
  logic                         flush;
  logic                         out_valid;
  logic                         out_ready;
  logic [LANES-1:0]             out_lane_valid;
  logic [6*LANES-1:0]           out_opcode;
  logic [5*LANES-1:0]           out_rd;
  logic [LANES-1:0]             out_reg_write;
  logic [LANES-1:0]             out_branch;
  logic [5*LANES-1:0]           out_shamt;
  logic [6*LANES-1:0]           out_funct;
  logic [26*LANES-1:0]          out_target;
  logic [DATA_W*LANES-1:0]      out_pc;
  logic [DATA_W*LANES-1:0]      out_val1;
  logic [DATA_W*LANES-1:0]      out_val2;
  logic [DATA_W*LANES-1:0]      out_val3;
  logic [CNT_W-1:0]             bubble_cnt;
  modport master (
    output in_valid, in_lane_valid, in_opcode, in_rd, in_reg_write, in_branch, in_shamt,
           in_funct, in_imm, in_target, in_pc, in_rs_val, in_rt_val, fwd_hit_rs, fwd_hit_rt,
           fwd_val, hazard_stall, flush, out_ready,
    input  in_ready, out_valid, out_lane_valid, out_opcode, out_rd, out_reg_write, out_branch,
           out_shamt, out_funct, out_target, out_pc, out_val1, out_val2, out_val3, bubble_cnt
  );
  modport slave (
    input  in_valid, in_lane_valid, in_opcode, in_rd, in_reg_write, in_branch, in_shamt,
           in_funct, in_imm, in_target, in_pc, in_rs_val, in_rt_val, fwd_hit_rs, fwd_hit_rt,
           fwd_val, hazard_stall, flush, out_ready,
    output in_ready, out_valid, out_lane_valid, out_opcode, out_rd, out_reg_write, out_branch,
           out_shamt, out_funct, out_target, out_pc, out_val1, out_val2, out_val3, bubble_cnt
  );
endinterface

// File: rtl/rd_issue_stage.sv
// rd_issue_stage: multi-lane decode-to-execute register with operand forwarding, immediate extension and skid buffer
module rd_issue_stage #(
  parameter int LANES    = 2,
  parameter int DATA_W   = 32,
  parameter int FWD_SRCS = 3,
  parameter int CNT_W    = 16
) (
  input logic          clk,
  input logic          rst_n,
  rd_issue_stage_if.slave bus
);
  typedef struct packed {
    logic [LANES-1:0]        lane_valid;
    logic [6*LANES-1:0]      opcode;
    logic [5*LANES-1:0]      rd;
    logic [LANES-1:0]        reg_write;
    logic [LANES-1:0]        branch;
    logic [5*LANES-1:0]      shamt;
    logic [6*LANES-1:0]      funct;
    logic [26*LANES-1:0]     target;
    logic [DATA_W*LANES-1:0] pc;
    logic [DATA_W*LANES-1:0] val1;
    logic [DATA_W*LANES-1:0] val2;
    logic [DATA_W*LANES-1:0] val3;
  } bundle_t;
  bundle_t          cap, out_q, skid_q;
  logic             out_v, skid_v, slot_free, accept, bubble;
  logic [CNT_W-1:0] cnt;
  // Highest index applied first so the lowest-indexed (youngest) hit wins
  function automatic logic [DATA_W-1:0] pick(input logic [FWD_SRCS-1:0] hit,
                                             input logic [DATA_W-1:0] rf,
                                             input logic [DATA_W*FWD_SRCS-1:0] fv);
    pick = rf;
    for (int s = FWD_SRCS - 1; s >= 0; s--)
      if (hit[s]) pick = fv[DATA_W*s +: DATA_W];
  endfunction
  function automatic logic [DATA_W-1:0] ext_imm(input logic [5:0] op, input logic br,
                                                input logic [15:0] imm);
    logic [DATA_W-1:0] se;
    se = {{(DATA_W-16){imm[15]}}, imm};
    ext_imm = br ? se << 2 :
              (op == 6'd12 || op == 6'd13 || op == 6'd14) ? DATA_W'(imm) :
              op == 6'd15 ? DATA_W'({imm, 16'h0000}) : se;
  endfunction
  assign bus.in_ready = !skid_v && !bus.hazard_stall && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign slot_free    = !out_v || bus.out_ready;
  assign bubble       = bus.hazard_stall && bus.in_valid && slot_free && !skid_v && !bus.flush;
  always_comb begin
    cap = '0;
    for (int l = 0; l < LANES; l++) begin
      cap.lane_valid[l]            = bus.in_lane_valid[l];
      cap.opcode[6*l +: 6]         = bus.in_lane_valid[l] ? bus.in_opcode[6*l +: 6] : '0;
      cap.rd[5*l +: 5]             = bus.in_lane_valid[l] ? bus.in_rd[5*l +: 5] : '0;
      cap.reg_write[l]             = bus.in_lane_valid[l] && bus.in_reg_write[l];
      cap.branch[l]                = bus.in_lane_valid[l] && bus.in_branch[l];
      cap.shamt[5*l +: 5]          = bus.in_lane_valid[l] ? bus.in_shamt[5*l +: 5] : '0;
      cap.funct[6*l +: 6]          = bus.in_lane_valid[l] ? bus.in_funct[6*l +: 6] : '0;
      cap.target[26*l +: 26]       = bus.in_lane_valid[l] ? bus.in_target[26*l +: 26] : '0;
      cap.pc[DATA_W*l +: DATA_W]   = bus.in_lane_valid[l] ? bus.in_pc + DATA_W'(4 * l) : '0;
      cap.val1[DATA_W*l +: DATA_W] = bus.in_lane_valid[l] ?
        pick(bus.fwd_hit_rs[FWD_SRCS*l +: FWD_SRCS], bus.in_rs_val[DATA_W*l +: DATA_W], bus.fwd_val) : '0;
      cap.val2[DATA_W*l +: DATA_W] = bus.in_lane_valid[l] ?
        pick(bus.fwd_hit_rt[FWD_SRCS*l +: FWD_SRCS], bus.in_rt_val[DATA_W*l +: DATA_W], bus.fwd_val) : '0;
      cap.val3[DATA_W*l +: DATA_W] = bus.in_lane_valid[l] ?
        ext_imm(bus.in_opcode[6*l +: 6], bus.in_branch[l], bus.in_imm[16*l +: 16]) : '0;
    end
  end
  // Skid only fills while the output slot is blocked; in_ready drops as soon as it is full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      out_q  <= '0;
      skid_v <= 1'b0;
      skid_q <= '0;
    end else if (bus.flush) begin
      out_v  <= 1'b0;
      out_q  <= '0;
      skid_v <= 1'b0;
      skid_q <= '0;
    end else if (slot_free) begin
      out_v <= skid_v || accept;
      if (skid_v) begin
        out_q  <= skid_q;
        skid_v <= 1'b0;
      end else if (accept) out_q <= cap;
    end else if (accept) begin
      skid_q <= cap;
      skid_v <= 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (bubble && cnt != '1) cnt <= cnt + CNT_W'(1);
  end
  assign bus.out_valid      = out_v;
  assign bus.out_lane_valid = out_q.lane_valid;
  assign bus.out_opcode     = out_q.opcode;
  assign bus.out_rd         = out_q.rd;
  assign bus.out_reg_write  = out_q.reg_write;
  assign bus.out_branch     = out_q.branch;
  assign bus.out_shamt      = out_q.shamt;
  assign bus.out_funct      = out_q.funct;
  assign bus.out_target     = out_q.target;
  assign bus.out_pc         = out_q.pc;
  assign bus.out_val1       = out_q.val1;
  assign bus.out_val2       = out_q.val2;
  assign bus.out_val3       = out_q.val3;
  assign bus.bubble_cnt     = cnt;
endmodule

// File: tb/tb_rd_issue_stage.sv
// tb_rd_issue_stage: directed checks of forwarding, immediates, backpressure, bubbles, flush and reset
module tb_rd_issue_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  always #5 clk = ~clk;
  rd_issue_stage_if #(.LANES(2), .DATA_W(32), .FWD_SRCS(3), .CNT_W(16)) b1 ();
  rd_issue_stage_if #(.LANES(2), .DATA_W(32), .FWD_SRCS(3), .CNT_W(2))  b2 ();
  rd_issue_stage #(.LANES(2), .DATA_W(32), .FWD_SRCS(3), .CNT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  rd_issue_stage #(.LANES(2), .DATA_W(32), .FWD_SRCS(3), .CNT_W(2))  u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  assign b2.in_valid      = b1.in_valid;
  assign b2.hazard_stall  = b1.hazard_stall;
  assign b2.flush         = b1.flush;
  assign b2.out_ready     = b1.out_ready;
  assign b2.in_lane_valid = '0;
  assign b2.in_opcode     = '0;
  assign b2.in_rd         = '0;
  assign b2.in_reg_write  = '0;
  assign b2.in_branch     = '0;
  assign b2.in_shamt      = '0;
  assign b2.in_funct      = '0;
  assign b2.in_imm        = '0;
  assign b2.in_target     = '0;
  assign b2.in_pc         = '0;
  assign b2.in_rs_val     = '0;
  assign b2.in_rt_val     = '0;
  assign b2.fwd_hit_rs    = '0;
  assign b2.fwd_hit_rt    = '0;
  assign b2.fwd_val       = '0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    b1.in_valid = 0; b1.in_lane_valid = '0; b1.in_opcode = '0; b1.in_rd = '0;
    b1.in_reg_write = '0; b1.in_branch = '0; b1.in_shamt = '0; b1.in_funct = '0;
    b1.in_imm = '0; b1.in_target = '0; b1.in_pc = '0; b1.in_rs_val = '0; b1.in_rt_val = '0;
    b1.fwd_hit_rs = '0; b1.fwd_hit_rt = '0; b1.fwd_val = '0; b1.hazard_stall = 0; b1.flush = 0;
  endtask
  task automatic bundle(input logic [31:0] pc);
    clr();
    b1.in_valid = 1; b1.in_lane_valid = 2'b11; b1.in_pc = pc;
  endtask
  initial begin
    clr();
    b1.out_ready = 1;
    tick(); tick();
    chk("rst_out_valid", 64'(b1.out_valid), 64'd0);
    chk("rst_bubble_cnt", 64'(b1.bubble_cnt), 64'd0);
    rst_n = 1;
    #1;
    chk("rst_in_ready", 64'(b1.in_ready), 64'd1);
    // forwarding priority, branch / zero-extended immediates, PC wrap
    bundle(32'hFFFF_FFFC);
    b1.in_opcode = {6'd13, 6'd0}; b1.in_branch = 2'b01; b1.in_imm = {16'hFFFC, 16'hFFFC};
    b1.in_rs_val = {32'h88, 32'h99}; b1.in_rt_val = {32'h77, 32'h55};
    b1.fwd_hit_rs = {3'b000, 3'b110}; b1.fwd_hit_rt = {3'b001, 3'b000};
    b1.fwd_val = {32'h33, 32'h22, 32'h11};
    tick();
    chk("fwd_out_valid", 64'(b1.out_valid), 64'd1);
    chk("fwd_rs_l0", 64'(b1.out_val1[31:0]), 64'h22);
    chk("fwd_rs_l1_nohit", 64'(b1.out_val1[63:32]), 64'h88);
    chk("fwd_rt_l0_nohit", 64'(b1.out_val2[31:0]), 64'h55);
    chk("fwd_rt_l1", 64'(b1.out_val2[63:32]), 64'h11);
    chk("imm_branch", 64'(b1.out_val3[31:0]), 64'hFFFF_FFF0);
    chk("imm_op13", 64'(b1.out_val3[63:32]), 64'h0000_FFFC);
    chk("pc_l0", 64'(b1.out_pc[31:0]), 64'hFFFF_FFFC);
    chk("pc_l1_wrap", 64'(b1.out_pc[63:32]), 64'h0);
    // LUI and plain sign extension, register-file operand
    bundle(32'h0);
    b1.in_opcode = {6'd8, 6'd15}; b1.in_imm = {16'hFFFC, 16'h1234};
    b1.in_rs_val = {32'h88, 32'h99};
    tick();
    chk("imm_op15", 64'(b1.out_val3[31:0]), 64'h1234_0000);
    chk("imm_op8", 64'(b1.out_val3[63:32]), 64'hFFFF_FFFC);
    chk("rs_nohit", 64'(b1.out_val1[31:0]), 64'h99);
    clr();
    tick();
    chk("drain_out_valid", 64'(b1.out_valid), 64'd0);
    // backpressure: A held, B in skid, C refused until release
    b1.out_ready = 0;
    bundle(32'h100);
    tick();
    chk("bp_a_out", 64'(b1.out_pc[31:0]), 64'h100);
    chk("bp_ready_a", 64'(b1.in_ready), 64'd1);
    bundle(32'h200);
    tick();
    chk("bp_a_held", 64'(b1.out_pc[31:0]), 64'h100);
    chk("bp_ready_skid", 64'(b1.in_ready), 64'd0);
    bundle(32'h300);
    tick();
    chk("bp_a_held2", 64'(b1.out_pc[31:0]), 64'h100);
    chk("bp_valid_held", 64'(b1.out_valid), 64'd1);
    b1.out_ready = 1;
    tick();
    chk("bp_b_out", 64'(b1.out_pc[31:0]), 64'h200);
    tick();
    chk("bp_c_out", 64'(b1.out_pc[31:0]), 64'h300);
    chk("bp_c_valid", 64'(b1.out_valid), 64'd1);
    clr();
    tick();
    chk("bp_no_dup", 64'(b1.out_valid), 64'd0);
    // bubbles and counter saturation on the narrow-counter instance
    bundle(32'h600);
    b1.hazard_stall = 1;
    #1;
    chk("stall_in_ready", 64'(b1.in_ready), 64'd0);
    tick();
    chk("bubble1", 64'(b1.out_valid), 64'd0);
    tick();
    chk("bubble2", 64'(b1.out_valid), 64'd0);
    tick();
    chk("bubble3", 64'(b1.out_valid), 64'd0);
    chk("bubble_cnt3", 64'(b1.bubble_cnt), 64'd3);
    chk("bubble_cnt3_w2", 64'(b2.bubble_cnt), 64'd3);
    tick(); tick();
    chk("bubble_cnt5", 64'(b1.bubble_cnt), 64'd5);
    chk("bubble_sat_w2", 64'(b2.bubble_cnt), 64'd3);
    // lane1 invalid, then flush with output and skid both full
    b1.out_ready = 0;
    bundle(32'h400);
    b1.in_lane_valid = 2'b01; b1.in_opcode = {6'd5, 6'd4}; b1.in_rs_val = {32'hAAAA, 32'h1};
    tick();
    chk("lane_valid", 64'(b1.out_lane_valid), 64'b01);
    chk("lane1_opcode", 64'(b1.out_opcode[11:6]), 64'd0);
    chk("lane1_val1", 64'(b1.out_val1[63:32]), 64'd0);
    chk("lane0_val1", 64'(b1.out_val1[31:0]), 64'h1);
    bundle(32'h500);
    tick();
    chk("flush_skid_full", 64'(b1.in_ready), 64'd0);
    b1.flush = 1;
    tick();
    chk("flush_out_valid", 64'(b1.out_valid), 64'd0);
    chk("flush_zero_pc", 64'(b1.out_pc[31:0]), 64'd0);
    clr();
    b1.out_ready = 1;
    #1;
    chk("flush_skid_empty", 64'(b1.in_ready), 64'd1);
    tick();
    chk("flush_no_skid_out", 64'(b1.out_valid), 64'd0);
    chk("flush_cnt_kept", 64'(b1.bubble_cnt), 64'd5);
    // asynchronous reset mid-stream
    b1.out_ready = 0;
    bundle(32'h700);
    b1.in_imm = {16'h1, 16'h1};
    tick();
    chk("pre_rst_valid", 64'(b1.out_valid), 64'd1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_out_valid", 64'(b1.out_valid), 64'd0);
    chk("arst_pc", 64'(b1.out_pc), 64'd0);
    chk("arst_val3", 64'(b1.out_val3), 64'd0);
    chk("arst_cnt", 64'(b1.bubble_cnt), 64'd0);
    rst_n = 1;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
